// File: rtl/small_fifo_ctl.sv
// -----------------------------------------------------------------------------
// small_fifo_ctl
//
// Small synchronous FIFO with a selectable read style:
//   FALLTHROUGH = 0 : registered read, dout updates the cycle after rd_en.
//   FALLTHROUGH = 1 : first-word-fall-through, dout shows the head word
//                     whenever empty is low and rd_en acts as a pop.
// Writes to a full FIFO and reads from an empty FIFO are dropped and
// flagged with one-cycle overflow/underflow pulses. Occupancy is held in
// its own counter. Every output comes from a register or a decode of the
// registered count/valid bit, so no input reaches an output combinationally.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   din          write data (WIDTH bits)
//   wr_en        write request
//   rd_en        read request (mode 0) / pop acknowledge (mode 1)
//   dout         registered read data
//   full         count == MAX_DEPTH
//   nearly_full  count >= MAX_DEPTH-1
//   prog_full    count >= PROG_FULL_THRESHOLD
//   empty        mode 0: count == 0; mode 1: dout not valid
//   prog_empty   count <= PROG_EMPTY_THRESHOLD
//   count        words held, including the FWFT output register
//   overflow     one-cycle pulse after a dropped write
//   underflow    one-cycle pulse after a dropped read
// -----------------------------------------------------------------------------
module small_fifo_ctl #(
    parameter int WIDTH                = 72,
    parameter int MAX_DEPTH_BITS       = 3,
    parameter int PROG_FULL_THRESHOLD  = 2**MAX_DEPTH_BITS - 1,
    parameter int PROG_EMPTY_THRESHOLD = 1,
    parameter int FALLTHROUGH          = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        din,
    input  logic                    wr_en,
    input  logic                    rd_en,
    output logic [WIDTH-1:0]        dout,
    output logic                    full,
    output logic                    nearly_full,
    output logic                    prog_full,
    output logic                    empty,
    output logic                    prog_empty,
    output logic [MAX_DEPTH_BITS:0] count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int MAX_DEPTH = 2**MAX_DEPTH_BITS;
    localparam int CW        = MAX_DEPTH_BITS + 1;
    localparam bit FWFT      = (FALLTHROUGH != 0);

    localparam logic [CW-1:0]             DEPTH_C = CW'(MAX_DEPTH);
    localparam logic [CW-1:0]             PF_C    = CW'(PROG_FULL_THRESHOLD);
    localparam logic [CW-1:0]             PE_C    = CW'(PROG_EMPTY_THRESHOLD);
    localparam logic [CW-1:0]             ONE_C   = CW'(1);
    localparam logic [MAX_DEPTH_BITS-1:0] PTR_ONE = MAX_DEPTH_BITS'(1);

    logic [WIDTH-1:0]          mem [MAX_DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [CW-1:0]             count_q;
    logic                      valid_q;      // FWFT output register holds a word
    logic [WIDTH-1:0]          dout_q;
    logic                      overflow_q;
    logic                      underflow_q;

    logic          empty_int;
    logic          full_int;
    logic          rd_acc;
    logic          wr_acc;
    logic          mem_pop;                  // a word leaves the memory array this edge
    logic          valid_d;
    logic [CW-1:0] mem_words;                // words in the array, excluding the output register
    logic [CW-1:0] count_d;

    always_comb begin
        // NOTE: every always_comb target is given a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        empty_int = FWFT ? ~valid_q : (count_q == '0);
        full_int  = (count_q == DEPTH_C);
        rd_acc    = rd_en & ~empty_int;
        // A simultaneous accepted read frees a slot, so writes at full still go in.
        wr_acc    = wr_en & (~full_int | rd_acc);
        mem_words = count_q - CW'(valid_q);

        // In FWFT mode the output register refills from memory whenever it is
        // vacant or being popped; the new word is not visible until the next edge.
        if (FWFT) begin
            mem_pop = (~valid_q | rd_acc) & (mem_words != '0);
        end else begin
            mem_pop = rd_acc;
        end

        valid_d = valid_q;
        if (FWFT) begin
            if (mem_pop) begin
                valid_d = 1'b1;
            end else if (rd_acc) begin
                valid_d = 1'b0;
            end
        end

        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            dout_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (mem_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                dout_q <= mem[rd_ptr];
            end
            count_q     <= count_d;
            valid_q     <= valid_d;
            overflow_q  <= wr_en & ~wr_acc;
            underflow_q <= rd_en & ~rd_acc;
        end
    end

    // NOTE: the storage array has no reset; stale words are unreachable once
    // the pointers and count are cleared, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (wr_acc && !reset) begin
            mem[wr_ptr] <= din;
        end
    end

    assign dout        = dout_q;
    assign full        = full_int;
    assign nearly_full = (count_q >= DEPTH_C - ONE_C);
    assign prog_full   = (count_q >= PF_C);
    assign empty       = empty_int;
    assign prog_empty  = (count_q <= PE_C);
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_small_fifo_ctl.sv
// -----------------------------------------------------------------------------
// tb_small_fifo_ctl
//
// Three instances share one stimulus stream:
//   u0 : registered read, default thresholds (prog_full 7, prog_empty 1)
//   u1 : FWFT, default thresholds
//   u2 : registered read, prog_full 5, prog_empty 2
// Each instance has a queue-style reference model (oldest word at index 0).
// The model advances at each rising edge; a negedge process compares all
// outputs against it, and the directed sections add literal expectations.
// -----------------------------------------------------------------------------
module tb_small_fifo_ctl;

    localparam int WIDTH = 72;
    localparam int DEPTH = 8;
    localparam int NI    = 3;

    logic             clk;
    logic             reset;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] din;

    logic [WIDTH-1:0] dout_o        [NI];
    logic             full_o        [NI];
    logic             nearly_full_o [NI];
    logic             prog_full_o   [NI];
    logic             empty_o       [NI];
    logic             prog_empty_o  [NI];
    logic [3:0]       count_o       [NI];
    logic             overflow_o    [NI];
    logic             underflow_o   [NI];

    // Per-instance configuration as seen by the model.
    int m_mode [NI] = '{0, 1, 0};
    int m_pf   [NI] = '{7, 7, 5};
    int m_pe   [NI] = '{1, 1, 2};

    // Reference model state.
    logic [WIDTH-1:0] m_it    [NI][DEPTH];
    int               m_n     [NI];
    logic             m_valid [NI];
    logic [WIDTH-1:0] m_dout  [NI];
    logic             m_ovf   [NI];
    logic             m_unf   [NI];

    int  n_tests = 0;
    int  n_fail  = 0;
    logic chk_en = 1'b0;

    small_fifo_ctl #(.WIDTH(WIDTH), .MAX_DEPTH_BITS(3), .PROG_FULL_THRESHOLD(7),
                     .PROG_EMPTY_THRESHOLD(1), .FALLTHROUGH(0)) u0 (
        .clk(clk), .reset(reset), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(dout_o[0]), .full(full_o[0]), .nearly_full(nearly_full_o[0]),
        .prog_full(prog_full_o[0]), .empty(empty_o[0]), .prog_empty(prog_empty_o[0]),
        .count(count_o[0]), .overflow(overflow_o[0]), .underflow(underflow_o[0]));

    small_fifo_ctl #(.WIDTH(WIDTH), .MAX_DEPTH_BITS(3), .PROG_FULL_THRESHOLD(7),
                     .PROG_EMPTY_THRESHOLD(1), .FALLTHROUGH(1)) u1 (
        .clk(clk), .reset(reset), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(dout_o[1]), .full(full_o[1]), .nearly_full(nearly_full_o[1]),
        .prog_full(prog_full_o[1]), .empty(empty_o[1]), .prog_empty(prog_empty_o[1]),
        .count(count_o[1]), .overflow(overflow_o[1]), .underflow(underflow_o[1]));

    small_fifo_ctl #(.WIDTH(WIDTH), .MAX_DEPTH_BITS(3), .PROG_FULL_THRESHOLD(5),
                     .PROG_EMPTY_THRESHOLD(2), .FALLTHROUGH(0)) u2 (
        .clk(clk), .reset(reset), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(dout_o[2]), .full(full_o[2]), .nearly_full(nearly_full_o[2]),
        .prog_full(prog_full_o[2]), .empty(empty_o[2]), .prog_empty(prog_empty_o[2]),
        .count(count_o[2]), .overflow(overflow_o[2]), .underflow(underflow_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] rnd_word();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[WIDTH-1:0];
    endfunction

    // Advance every model by one rising edge using the inputs applied before it.
    task automatic model_step();
        logic             emp;
        logic             racc;
        logic             wacc;
        int               mem_words;
        for (int k = 0; k < NI; k++) begin
            if (reset) begin
                m_n[k]     = 0;
                m_valid[k] = 1'b0;
                m_dout[k]  = '0;
                m_ovf[k]   = 1'b0;
                m_unf[k]   = 1'b0;
            end else begin
                emp       = (m_mode[k] != 0) ? !m_valid[k] : (m_n[k] == 0);
                racc      = rd_en && !emp;
                wacc      = wr_en && ((m_n[k] < DEPTH) || racc);
                m_ovf[k]  = wr_en && !wacc;
                m_unf[k]  = rd_en && emp;
                mem_words = m_n[k] - (((m_mode[k] != 0) && m_valid[k]) ? 1 : 0);
                if (racc) begin
                    if (m_mode[k] == 0) m_dout[k] = m_it[k][0];
                    for (int i = 0; i < DEPTH - 1; i++) m_it[k][i] = m_it[k][i+1];
                    m_n[k]--;
                end
                if ((m_mode[k] != 0) && (!m_valid[k] || racc)) begin
                    // The oldest remaining word is the next one shown, if memory had one.
                    if (mem_words > 0) begin
                        m_valid[k] = 1'b1;
                        m_dout[k]  = m_it[k][0];
                    end else begin
                        m_valid[k] = 1'b0;
                    end
                end
                if (wacc) begin
                    m_it[k][m_n[k]] = din;
                    m_n[k]++;
                end
            end
        end
    endtask

    task automatic tick(input logic rs, input logic w, input logic r,
                        input logic [WIDTH-1:0] d);
        reset = rs;
        wr_en = w;
        rd_en = r;
        din   = d;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // Every-cycle comparison of all instances against their models.
    always @(negedge clk) begin : cmp
        int   n;
        logic e_empty;
        if (chk_en) begin
            for (int k = 0; k < NI; k++) begin
                n       = m_n[k];
                e_empty = (m_mode[k] != 0) ? !m_valid[k] : (n == 0);
                check($sformatf("u%0d.count", k),       WIDTH'(count_o[k]),       WIDTH'(n));
                check($sformatf("u%0d.empty", k),       WIDTH'(empty_o[k]),       WIDTH'(e_empty));
                check($sformatf("u%0d.full", k),        WIDTH'(full_o[k]),        WIDTH'(n == DEPTH));
                check($sformatf("u%0d.nearly_full", k), WIDTH'(nearly_full_o[k]), WIDTH'(n >= DEPTH - 1));
                check($sformatf("u%0d.prog_full", k),   WIDTH'(prog_full_o[k]),   WIDTH'(n >= m_pf[k]));
                check($sformatf("u%0d.prog_empty", k),  WIDTH'(prog_empty_o[k]),  WIDTH'(n <= m_pe[k]));
                check($sformatf("u%0d.overflow", k),    WIDTH'(overflow_o[k]),    WIDTH'(m_ovf[k]));
                check($sformatf("u%0d.underflow", k),   WIDTH'(underflow_o[k]),   WIDTH'(m_unf[k]));
                if ((m_mode[k] == 0) || !e_empty)
                    check($sformatf("u%0d.dout", k), dout_o[k], m_dout[k]);
            end
        end
    end

    initial begin
        int               w_bit;
        int               r_bit;
        logic [WIDTH-1:0] exp_d;

        reset = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        for (int k = 0; k < NI; k++) begin
            m_n[k] = 0; m_valid[k] = 1'b0; m_dout[k] = '0; m_ovf[k] = 1'b0; m_unf[k] = 1'b0;
        end
        @(negedge clk);

        // Reset state.
        tick(1'b1, 1'b0, 1'b0, '0);
        tick(1'b1, 1'b0, 1'b0, '0);
        chk_en = 1'b1;
        check("rst u0.count",      WIDTH'(count_o[0]),       WIDTH'(0));
        check("rst u0.empty",      WIDTH'(empty_o[0]),       WIDTH'(1));
        check("rst u0.dout",       dout_o[0],                WIDTH'(0));
        check("rst u0.prog_empty", WIDTH'(prog_empty_o[0]),  WIDTH'(1));
        check("rst u0.full",       WIDTH'(full_o[0]),        WIDTH'(0));
        check("rst u0.nearly_full",WIDTH'(nearly_full_o[0]), WIDTH'(0));
        check("rst u0.prog_full",  WIDTH'(prog_full_o[0]),   WIDTH'(0));
        check("rst u1.empty",      WIDTH'(empty_o[1]),       WIDTH'(1));
        check("rst u2.prog_empty", WIDTH'(prog_empty_o[2]),  WIDTH'(1));

        // Fill with 0x01..0x08.
        tick(1'b0, 1'b0, 1'b0, '0);
        for (int i = 1; i <= 8; i++) begin
            tick(1'b0, 1'b1, 1'b0, WIDTH'(i));
            if (i == 1) begin
                check("fwft wr1 u1.count", WIDTH'(count_o[1]), WIDTH'(1));
                check("fwft wr1 u1.empty", WIDTH'(empty_o[1]), WIDTH'(1));
            end
            if (i == 2) begin
                check("fwft wr2 u1.empty",      WIDTH'(empty_o[1]),      WIDTH'(0));
                check("fwft wr2 u1.dout",       dout_o[1],               WIDTH'(1));
                check("thr c2 u2.prog_empty",   WIDTH'(prog_empty_o[2]), WIDTH'(1));
            end
            if (i == 3) check("thr c3 u2.prog_empty", WIDTH'(prog_empty_o[2]), WIDTH'(0));
            if (i == 4) check("thr c4 u2.prog_full",  WIDTH'(prog_full_o[2]),  WIDTH'(0));
            if (i == 5) check("thr c5 u2.prog_full",  WIDTH'(prog_full_o[2]),  WIDTH'(1));
            if (i == 6) check("fill6 u0.prog_full",   WIDTH'(prog_full_o[0]),  WIDTH'(0));
            if (i == 7) begin
                check("fill7 u0.prog_full",   WIDTH'(prog_full_o[0]),   WIDTH'(1));
                check("fill7 u0.nearly_full", WIDTH'(nearly_full_o[0]), WIDTH'(1));
                check("fill7 u2.nearly_full", WIDTH'(nearly_full_o[2]), WIDTH'(1));
                check("fill7 u0.full",        WIDTH'(full_o[0]),        WIDTH'(0));
            end
            if (i == 8) begin
                check("fill8 u0.full",  WIDTH'(full_o[0]),  WIDTH'(1));
                check("fill8 u0.count", WIDTH'(count_o[0]), WIDTH'(8));
            end
        end

        // Ninth write is dropped.
        tick(1'b0, 1'b1, 1'b0, WIDTH'(9));
        check("ovf u0.overflow", WIDTH'(overflow_o[0]), WIDTH'(1));
        check("ovf u0.count",    WIDTH'(count_o[0]),    WIDTH'(8));
        check("ovf u1.overflow", WIDTH'(overflow_o[1]), WIDTH'(1));
        tick(1'b0, 1'b0, 1'b0, '0);
        check("ovf end u0.overflow", WIDTH'(overflow_o[0]), WIDTH'(0));

        // Drain: registered data one cycle after rd_en; FWFT shows the next word each cycle.
        for (int i = 1; i <= 8; i++) begin
            tick(1'b0, 1'b0, 1'b1, '0);
            check($sformatf("drain%0d u0.dout", i), dout_o[0], WIDTH'(i));
            if (i < 8) check($sformatf("drain%0d u1.dout", i), dout_o[1], WIDTH'(i + 1));
        end
        check("drain u0.empty", WIDTH'(empty_o[0]), WIDTH'(1));
        check("drain u1.empty", WIDTH'(empty_o[1]), WIDTH'(1));

        // FWFT latency and underflow.
        tick(1'b0, 1'b1, 1'b0, WIDTH'('hAA));
        check("aa u1.count", WIDTH'(count_o[1]), WIDTH'(1));
        check("aa u1.empty", WIDTH'(empty_o[1]), WIDTH'(1));
        tick(1'b0, 1'b0, 1'b0, '0);
        check("aa+1 u1.empty", WIDTH'(empty_o[1]), WIDTH'(0));
        check("aa+1 u1.dout",  dout_o[1],          WIDTH'('hAA));
        tick(1'b0, 1'b0, 1'b1, '0);
        check("pop u1.empty", WIDTH'(empty_o[1]), WIDTH'(1));
        check("pop u0.dout",  dout_o[0],          WIDTH'('hAA));
        tick(1'b0, 1'b0, 1'b1, '0);
        check("unf u1.underflow", WIDTH'(underflow_o[1]), WIDTH'(1));
        check("unf u1.dout",      dout_o[1],              WIDTH'('hAA));
        check("unf u0.underflow", WIDTH'(underflow_o[0]), WIDTH'(1));
        check("unf u0.dout",      dout_o[0],              WIDTH'('hAA));
        tick(1'b0, 1'b0, 1'b0, '0);
        check("unf end u1.underflow", WIDTH'(underflow_o[1]), WIDTH'(0));

        // Simultaneous write and read at full.
        tick(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 1'b0, WIDTH'('h10 + i));
        tick(1'b0, 1'b1, 1'b1, WIDTH'('h20));
        check("full rw u0.overflow", WIDTH'(overflow_o[0]), WIDTH'(0));
        check("full rw u0.count",    WIDTH'(count_o[0]),    WIDTH'(8));
        check("full rw u0.dout",     dout_o[0],             WIDTH'('h10));
        check("full rw u1.count",    WIDTH'(count_o[1]),    WIDTH'(8));
        for (int j = 0; j < 8; j++) begin
            tick(1'b0, 1'b0, 1'b1, '0);
            exp_d = (j < 7) ? WIDTH'('h11 + j) : WIDTH'('h20);
            check($sformatf("full rw drain%0d u0.dout", j), dout_o[0], exp_d);
        end

        // Simultaneous write and read at empty.
        tick(1'b0, 1'b1, 1'b1, WIDTH'('h33));
        check("empty rw u0.underflow", WIDTH'(underflow_o[0]), WIDTH'(1));
        check("empty rw u0.count",     WIDTH'(count_o[0]),     WIDTH'(1));
        tick(1'b0, 1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, 1'b1, '0);
        check("empty rw u0.dout", dout_o[0], WIDTH'('h33));

        // Reset mid-burst with wr_en held high.
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, WIDTH'('h40 + i));
        check("pre-rst u0.count", WIDTH'(count_o[0]), WIDTH'(4));
        tick(1'b1, 1'b1, 1'b0, WIDTH'('h99));
        check("mid-rst u0.count",     WIDTH'(count_o[0]),     WIDTH'(0));
        check("mid-rst u0.empty",     WIDTH'(empty_o[0]),     WIDTH'(1));
        check("mid-rst u0.dout",      dout_o[0],              WIDTH'(0));
        check("mid-rst u0.overflow",  WIDTH'(overflow_o[0]),  WIDTH'(0));
        check("mid-rst u0.underflow", WIDTH'(underflow_o[0]), WIDTH'(0));
        tick(1'b0, 1'b1, 1'b0, WIDTH'('h55));
        tick(1'b0, 1'b0, 1'b1, '0);
        check("post-rst u0.dout", dout_o[0], WIDTH'('h55));
        tick(1'b0, 1'b0, 1'b0, '0);
        check("post-rst u0.empty", WIDTH'(empty_o[0]), WIDTH'(1));

        // Wrap: u0 occupancy held between 2 and 5 across pointer wrap.
        tick(1'b0, 1'b1, 1'b0, rnd_word());
        tick(1'b0, 1'b1, 1'b0, rnd_word());
        for (int i = 0; i < 20; i++) begin
            w_bit = (m_n[0] < 5) ? int'($urandom_range(0, 3) != 0) : 0;
            r_bit = (m_n[0] > 2) ? int'($urandom_range(0, 3) != 0) : 0;
            tick(1'b0, w_bit[0], r_bit[0], rnd_word());
            check($sformatf("wrap%0d u0.count in 2..5", i),
                  WIDTH'((count_o[0] >= 4'd2) && (count_o[0] <= 4'd5)), WIDTH'(1));
        end

        // Randomized traffic alternating fill-heavy and drain-heavy phases.
        for (int c = 0; c < 3000; c++) begin
            int   wp;
            logic rs;
            wp = (((c / 250) % 2) == 0) ? 70 : 30;
            rs = ($urandom_range(0, 199) == 0);
            tick(rs, ($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < (100 - wp)),
                 rnd_word());
        end

        tick(1'b0, 1'b0, 1'b0, '0);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/small_fifo_ctl.md
# small_fifo_ctl

Parametrised successor to the team's small synchronous FIFO. Adds a selectable first-word-fall-through (FWFT) read mode, a programmable empty threshold, an occupancy count output, and hardware-protected overflow/underflow. Illegal operations are dropped and flagged rather than corrupting state. Drop-in buffer for datapath modules (header queues, small packet-descriptor queues) that need either registered-read or show-ahead behaviour from one source.

## Interface
Parameters:
- WIDTH, 72, data width in bits.
- MAX_DEPTH_BITS, 3, log2 of capacity; capacity MAX_DEPTH = 2**MAX_DEPTH_BITS words.
- PROG_FULL_THRESHOLD, 2**MAX_DEPTH_BITS-1, prog_full asserted when count >= this value.
- PROG_EMPTY_THRESHOLD, 1, prog_empty asserted when count <= this value.
- FALLTHROUGH, 0, 0 = registered read (data valid the cycle after rd_en); 1 = FWFT (dout valid whenever empty=0).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- din  in  WIDTH  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request (mode 0) / pop acknowledge (mode 1).
- dout  out  WIDTH  read data, registered.
- full  out  1  count == MAX_DEPTH.
- nearly_full  out  1  count >= MAX_DEPTH-1.
- prog_full  out  1  count >= PROG_FULL_THRESHOLD.
- empty  out  1  mode 0: count == 0; mode 1: dout not valid.
- prog_empty  out  1  count <= PROG_EMPTY_THRESHOLD.
- count  out  MAX_DEPTH_BITS+1  words held (memory plus FWFT output register).
- overflow  out  1  one-cycle pulse: write dropped.
- underflow  out  1  one-cycle pulse: read dropped.

## Operation
- Storage: MAX_DEPTH x WIDTH array. Read and write pointers are MAX_DEPTH_BITS wide and wrap naturally modulo MAX_DEPTH. count is held in its own register, never derived from the pointers.
- Write accepted = wr_en & (~full | rd_accepted). rd_accepted is defined below.
- Write dropped (wr_en & full & ~rd_en) leaves pointers, count and memory unchanged and pulses overflow.
- Read accepted = rd_en & ~empty. Read on empty is dropped, pulses underflow, and leaves dout unchanged.
- count: +1 on write-only, -1 on read-only, unchanged on both-accepted or neither.
- Mode 0:
  - dout <= mem[rd_ptr] on an accepted read; otherwise dout holds.
  - wr_en & rd_en while empty: write accepted, read dropped (underflow=1), count 0->1.
- Mode 1:
  - A one-word output register feeds dout, with an internal valid bit; empty = ~valid.
  - When valid=0, or an accepted read pops the current word, and memory holds >=1 word, the register loads mem[rd_ptr].
  - On a pop with memory empty, valid clears.
  - Total capacity including the output register is MAX_DEPTH.
- Reset: pointers, count and valid cleared; dout=0; empty=1; prog_empty=1; full=nearly_full=prog_full=0; overflow=underflow=0. Reset mid-operation discards all contents, and the memory array itself is not cleared. Reset overrides wr_en/rd_en in that cycle and raises no error pulse.

## Timing
- All outputs are registered or decoded from registered count/valid only. There are no combinational paths from din/wr_en/rd_en to any output.
- Mode 0:
  - Write at edge N: count, empty and flags update after N.
  - Read at edge N: dout valid after N.
- Mode 1:
  - Write into an empty FIFO at edge N: count=1 after N, dout valid and empty=0 after N+1.
  - During the intervening cycle, count=1 with empty=1. This is legal.
  - Back-to-back pops with memory non-empty: a new word appears on dout every cycle.
- overflow/underflow are asserted for exactly the cycle after the offending edge.
- Full throughput: one write and one read per cycle in either mode, including at full (mode 1: when empty=0).

## Test plan
- Mode 0, depth 8: write 0x01..0x08 -> full=1, count=8, prog_full=1 after 7th write. 9th write -> overflow pulse, count stays 8. Eight reads -> dout 0x01..0x08 in order, each one cycle after rd_en, then empty=1.
- Mode 0 wrap: 20 interleaved writes/reads with count held between 2 and 5 -> dout sequence matches write order across pointer wrap, and count is never wrong.
- Mode 1: write 0xAA to an empty FIFO -> empty=0 and dout=0xAA two edges after the write. Pop with rd_en -> empty=1 next cycle. rd_en with empty=1 -> underflow pulse, dout unchanged.
- Simultaneous ops: at full, assert wr_en&rd_en -> no overflow, count stays 8, order preserved. At empty in mode 0 -> underflow=1, count becomes 1.
- Thresholds: PROG_FULL_THRESHOLD=5, PROG_EMPTY_THRESHOLD=2 -> prog_empty=1 at counts 0..2, prog_full=1 at counts >=5, nearly_full at count 7.
- Reset at count=4 mid-burst with wr_en high -> next cycle count=0, empty=1, dout=0, no error pulses. Subsequent write/read returns the new data only.
